yarp_branch_predict_unit: RTL and testbench
===========================================

# yarp_branch_predict_unit

Parametrised branch resolution and prediction unit for the YARP core. It generalises the combinational branch comparator to XLEN-bit operands. It adds a PC-indexed branch history table (BHT) of 2-bit saturating counters for fetch-stage prediction. It registers the resolved outcome with a mispredict flag, and keeps saturating branch and mispredict statistics counters. It sits between the execute stage, which supplies operands, and the fetch/PC logic, which consumes the prediction and the mispredict redirect.

## Interface
Parameters:
- XLEN, 32, operand width (≥ 8)
- BHT_DEPTH, 64, number of BHT entries (power of 2, ≥ 2); IDX_W = log2(BHT_DEPTH)
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- pred_pc_i  in  32  fetch PC to predict
- pred_taken_o  out  1  prediction for pred_pc_i (combinational)
- res_valid_i  in  1  a resolve request is present this cycle
- res_pc_i  in  32  PC of the instruction being resolved
- opr_a_i  in  XLEN  rs1 value
- opr_b_i  in  XLEN  rs2 value
- is_b_type_ctl_i  in  1  instruction is a conditional branch
- instr_func3_ctl_i  in  3  branch func3
- res_pred_taken_i  in  1  prediction that was used for this instruction
- res_valid_o  out  1  registered resolve result valid
- branch_taken_o  out  1  registered actual outcome
- mispredict_o  out  1  registered; actual outcome ≠ prediction
- stat_clr_i  in  1  synchronous clear of the statistics counters
- branch_cnt_o  out  CNT_W  resolved conditional branches, saturating
- mispredict_cnt_o  out  CNT_W  mispredicted branches, saturating

## Operation
- BHT index: pc[IDX_W+1:2] for both ports. Upper PC bits are ignored, so aliasing is allowed.
- Prediction: pred_taken_o = MSB of BHT[index(pred_pc_i)]. It is a pure read with no state change.
- Comparison: compute diff = {1'b0,a} + {1'b0,~b} + 1 over XLEN+1 bits.
  - eq = (a == b).
  - ltu = ~diff[XLEN].
  - lt = (a[XLEN-1] & ~b[XLEN-1]) | (~(a[XLEN-1]^b[XLEN-1]) & diff[XLEN-1]).
- func3 mapping:
  - 000 BEQ = eq; 001 BNE = ~eq.
  - 100 BLT = lt; 101 BGE = ~lt.
  - 110 BLTU = ltu; 111 BGEU = ~ltu.
  - 010 and 011 are illegal.
- An event is "counted" when res_valid_i & is_b_type_ctl_i & func3 is legal. On a counted event, at the clock edge:
  - BHT[index(res_pc_i)] increments if taken (saturates at 11), else decrements (saturates at 00).
  - branch_cnt_o increments.
  - mispredict_cnt_o increments if taken ≠ res_pred_taken_i.
- Non-counted resolve (res_valid_i with a non-branch or illegal func3):
  - res_valid_o still pulses.
  - branch_taken_o = 0, mispredict_o = 0.
  - No BHT or counter change.
- Statistics counters hold at all-ones; they do not wrap.
- stat_clr_i clears both counters to 0. It wins over a simultaneous increment. BHT is unaffected.
- Reset (asynchronous, any time, including mid-resolve):
  - All BHT entries become 2'b01 (weakly not-taken).
  - res_valid_o, branch_taken_o, mispredict_o, branch_cnt_o and mispredict_cnt_o become 0.
  - pred_taken_o therefore reads 0.
  - Any in-flight resolve is discarded.

## Timing
- pred_taken_o: zero latency, combinational from pred_pc_i and current BHT state.
- Resolve: 1-cycle latency. Inputs sampled at edge N appear on res_valid_o, branch_taken_o and mispredict_o after edge N. They hold for exactly one cycle unless another resolve arrives at edge N+1.
- res_valid_o = 0 whenever res_valid_i was 0 at the previous edge. branch_taken_o and mispredict_o are 0 in that case.
- Back-to-back resolves every cycle are supported with no bubbles.
- BHT update and counter increment occur at the same edge that registers the result. The new counter value is visible on pred_taken_o in the following cycle.
- Same-cycle predict and update of the same index: pred_taken_o shows the pre-update value (no bypass).
- Counters reflect the event one cycle after res_valid_i, aligned with res_valid_o.

## Test plan
- Reset then sweep pred_pc_i over all indices → pred_taken_o = 0 everywhere; all registered outputs and counters = 0.
- XLEN=32 compares:
  - a=0xFFFF_FFFF, b=0x0000_0001: BLT → taken=1; BLTU → 0; BGE → 0; BGEU → 1.
  - a=b=0x8000_0000: BEQ → 1, BNE → 0.
  - Each result appears one cycle after res_valid_i.
- Training at pc=0x0000_0040 (index 16):
  - Three taken BEQ resolves with res_pred_taken_i=0 → pred_taken_o for 0x40 goes to 1 after the 1st update (01→10), and the counter saturates at 11.
  - mispredict_o = 1, 1, 1.
  - branch_cnt_o = 3, mispredict_cnt_o = 3.
  - Then one not-taken resolve → entry 10, pred still 1.
- Aliasing: updating pc=0x40 also changes the prediction for pc=0x40+4·BHT_DEPTH (0x140 with default depth); pc=0x44 is unchanged.
- Non-counted cases: func3=010 with is_b_type=1, and is_b_type=0 with BEQ operands equal → res_valid_o=1, branch_taken_o=0, mispredict_o=0; no BHT or counter change.
- Counters and reset:
  - With CNT_W=4, 20 taken branches → branch_cnt_o holds 15.
  - stat_clr_i asserted together with a counted resolve → both counters read 0 next cycle.
  - Reset asserted mid-stream, between edges → outputs drop to 0 immediately and the BHT returns to 01.

Source files
------------

// File: rtl/yarp_branch_predict_unit_if.sv
// Bundle between execute/fetch logic and the branch predict unit.
// The master drives requests; the slave is the predict unit itself.
interface yarp_branch_predict_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      pred_pc_i;
  logic             pred_taken_o;
  logic             res_valid_i;
  logic [31:0]      res_pc_i;
  logic [XLEN-1:0]  opr_a_i;
  logic [XLEN-1:0]  opr_b_i;
  logic             is_b_type_ctl_i;
  logic [2:0]       instr_func3_ctl_i;
  logic             res_pred_taken_i;
  logic             res_valid_o;
  logic             branch_taken_o;
  logic             mispredict_o;
  logic             stat_clr_i;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispredict_cnt_o;

  modport master (
    output pred_pc_i, res_valid_i, res_pc_i, opr_a_i, opr_b_i, is_b_type_ctl_i,
           instr_func3_ctl_i, res_pred_taken_i, stat_clr_i,
    input  pred_taken_o, res_valid_o, branch_taken_o, mispredict_o, branch_cnt_o,
           mispredict_cnt_o
  );

  modport slave (
    input  pred_pc_i, res_valid_i, res_pc_i, opr_a_i, opr_b_i, is_b_type_ctl_i,
           instr_func3_ctl_i, res_pred_taken_i, stat_clr_i,
    output pred_taken_o, res_valid_o, branch_taken_o, mispredict_o, branch_cnt_o,
           mispredict_cnt_o
  );
endinterface

// File: rtl/yarp_branch_predict_unit.sv
// Branch resolution with a PC-indexed 2-bit BHT predictor, a registered
// resolve result with mispredict flag, and saturating statistics counters.
module yarp_branch_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input logic                      clk,
  input logic                      reset,
  yarp_branch_predict_unit_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [XLEN:0]    diff;
  logic             eq, lt, ltu;
  logic             legal_f3;
  logic             taken;
  logic             counted;
  logic [1:0]       bht_cur;
  logic [1:0]       bht_nxt;

  logic             res_valid_q, branch_taken_q, mispredict_q;
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  // Upper PC bits are deliberately ignored; aliasing is allowed.
  logic unused_pc;
  assign unused_pc = ^{bp.pred_pc_i[31:IDX_W+2], bp.pred_pc_i[1:0],
                       bp.res_pc_i[31:IDX_W+2], bp.res_pc_i[1:0]};

  assign pred_idx        = bp.pred_pc_i[IDX_W+1:2];
  assign res_idx         = bp.res_pc_i[IDX_W+1:2];
  assign bp.pred_taken_o = bht_q[pred_idx][1];

  // a - b over XLEN+1 bits; the carry-out is the unsigned not-less-than flag.
  assign diff = {1'b0, bp.opr_a_i} + {1'b0, ~bp.opr_b_i} + {{XLEN{1'b0}}, 1'b1};
  assign eq   = (bp.opr_a_i == bp.opr_b_i);
  assign ltu  = ~diff[XLEN];
  assign lt   = (bp.opr_a_i[XLEN-1] & ~bp.opr_b_i[XLEN-1]) |
                (~(bp.opr_a_i[XLEN-1] ^ bp.opr_b_i[XLEN-1]) & diff[XLEN-1]);

  assign legal_f3 = (bp.instr_func3_ctl_i[2:1] != 2'b01);
  assign counted  = bp.res_valid_i & bp.is_b_type_ctl_i & legal_f3;

  always_comb begin
    taken = 1'b0;
    unique case (bp.instr_func3_ctl_i)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    bht_cur = bht_q[res_idx];
    bht_nxt = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (counted) begin
      bht_q[res_idx] <= bht_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q    <= 1'b0;
      branch_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
    end else begin
      res_valid_q    <= bp.res_valid_i;
      branch_taken_q <= counted & taken;
      mispredict_q   <= counted & (taken != bp.res_pred_taken_i);
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bp.stat_clr_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (counted) begin
      if (!(&branch_cnt_q)) branch_cnt_q <= branch_cnt_q + 1'b1;
      if ((taken != bp.res_pred_taken_i) && !(&mispredict_cnt_q)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
    end
  end

  assign bp.res_valid_o      = res_valid_q;
  assign bp.branch_taken_o   = branch_taken_q;
  assign bp.mispredict_o     = mispredict_q;
  assign bp.branch_cnt_o     = branch_cnt_q;
  assign bp.mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: tb/tb_yarp_branch_predict_unit.sv
// Directed bench for yarp_branch_predict_unit (XLEN=32, 64 BHT entries, 4-bit counters).
module tb_yarp_branch_predict_unit;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned BHT_DEPTH = 64;
  localparam int unsigned CNT_W     = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  yarp_branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bp ();

  yarp_branch_predict_unit #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a resolve for one edge; result is checkable on return.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic btype, input logic [2:0] f3, input logic pt);
    bp.res_pc_i          = pc;
    bp.opr_a_i           = a;
    bp.opr_b_i           = b;
    bp.is_b_type_ctl_i   = btype;
    bp.instr_func3_ctl_i = f3;
    bp.res_pred_taken_i  = pt;
    bp.res_valid_i       = 1'b1;
    tick();
    bp.res_valid_i       = 1'b0;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    bp.pred_pc_i = pc;
    #1;
    check(tag, {31'd0, bp.pred_taken_o}, {31'd0, exp});
  endtask

  task automatic res_out(input string tag, input logic v, input logic t, input logic m);
    check({tag, ".valid"}, {31'd0, bp.res_valid_o}, {31'd0, v});
    check({tag, ".taken"}, {31'd0, bp.branch_taken_o}, {31'd0, t});
    check({tag, ".mispred"}, {31'd0, bp.mispredict_o}, {31'd0, m});
  endtask

  task automatic cnts(input string tag, input int br, input int mp);
    check({tag, ".branch_cnt"}, 32'(bp.branch_cnt_o), 32'(br));
    check({tag, ".mispred_cnt"}, 32'(bp.mispredict_cnt_o), 32'(mp));
  endtask

  initial begin
    reset                = 1'b1;
    bp.pred_pc_i         = '0;
    bp.res_valid_i       = 1'b0;
    bp.res_pc_i          = '0;
    bp.opr_a_i           = '0;
    bp.opr_b_i           = '0;
    bp.is_b_type_ctl_i   = 1'b0;
    bp.instr_func3_ctl_i = '0;
    bp.res_pred_taken_i  = 1'b0;
    bp.stat_clr_i        = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state: every entry weakly not-taken, outputs and counters zero.
    for (int i = 0; i < BHT_DEPTH; i++) pred_at("reset_sweep", 32'(i * 4), 1'b0);
    res_out("reset", 1'b0, 1'b0, 1'b0);
    cnts("reset", 0, 0);

    // Compares at pc 0x200 (index 0); predictions used are all 0.
    resolve(32'h200, 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b100, 1'b0);
    res_out("blt", 1'b1, 1'b1, 1'b1);
    resolve(32'h200, 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b110, 1'b0);
    res_out("bltu", 1'b1, 1'b0, 1'b0);
    resolve(32'h200, 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b101, 1'b0);
    res_out("bge", 1'b1, 1'b0, 1'b0);
    resolve(32'h200, 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b111, 1'b0);
    res_out("bgeu", 1'b1, 1'b1, 1'b1);
    resolve(32'h200, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b000, 1'b0);
    res_out("beq", 1'b1, 1'b1, 1'b1);
    resolve(32'h200, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b001, 1'b0);
    res_out("bne", 1'b1, 1'b0, 1'b0);
    cnts("compares", 6, 3);
    tick();
    res_out("idle", 1'b0, 1'b0, 1'b0);

    bp.stat_clr_i = 1'b1;
    tick();
    bp.stat_clr_i = 1'b0;
    cnts("clr", 0, 0);

    // Train index 16 (pc 0x40) taken three times with prediction 0.
    pred_at("pred40_init", 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      resolve(32'h40, 32'd5, 32'd5, 1'b1, 3'b000, 1'b0);
      res_out("train", 1'b1, 1'b1, 1'b1);
      pred_at("pred40_train", 32'h40, 1'b1);
    end
    cnts("train", 3, 3);
    pred_at("alias140", 32'h140, 1'b1);
    pred_at("pred44", 32'h44, 1'b0);

    // Not-taken resolve: entry 11 -> 10, prediction still 1.
    resolve(32'h40, 32'd5, 32'd5, 1'b1, 3'b001, 1'b1);
    res_out("nottaken", 1'b1, 1'b0, 1'b1);
    pred_at("pred40_after_nt", 32'h40, 1'b1);
    cnts("nottaken", 4, 4);

    // Same-cycle predict and update of index 17: pre-update value visible.
    bp.pred_pc_i         = 32'h44;
    bp.res_pc_i          = 32'h44;
    bp.opr_a_i           = 32'd7;
    bp.opr_b_i           = 32'd7;
    bp.is_b_type_ctl_i   = 1'b1;
    bp.instr_func3_ctl_i = 3'b000;
    bp.res_pred_taken_i  = 1'b0;
    bp.res_valid_i       = 1'b1;
    #1;
    check("no_bypass", {31'd0, bp.pred_taken_o}, 32'd0);
    tick();
    bp.res_valid_i = 1'b0;
    check("post_update44", {31'd0, bp.pred_taken_o}, 32'd1);
    cnts("same_cycle", 5, 5);

    // Non-counted: illegal func3 and non-branch.
    resolve(32'h40, 32'd1, 32'd1, 1'b1, 3'b010, 1'b0);
    res_out("illegal_f3", 1'b1, 1'b0, 1'b0);
    resolve(32'h4C, 32'd1, 32'd1, 1'b0, 3'b000, 1'b0);
    res_out("non_branch", 1'b1, 1'b0, 1'b0);
    pred_at("pred40_nc", 32'h40, 1'b1);
    pred_at("pred4c_nc", 32'h4C, 1'b0);
    cnts("non_counted", 5, 5);

    // 20 correctly predicted taken branches saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) resolve(32'h80, 32'd9, 32'd9, 1'b1, 3'b000, 1'b1);
    cnts("saturate", 15, 5);

    // Clear wins over a simultaneous counted mispredicted resolve.
    bp.stat_clr_i = 1'b1;
    resolve(32'h80, 32'd1, 32'd2, 1'b1, 3'b000, 1'b1);
    bp.stat_clr_i = 1'b0;
    res_out("clr_with_res", 1'b1, 1'b0, 1'b1);
    cnts("clr_with_res", 0, 0);

    // Asynchronous reset between edges with a result pending.
    resolve(32'h40, 32'd3, 32'd3, 1'b1, 3'b000, 1'b0);
    res_out("pre_reset", 1'b1, 1'b1, 1'b1);
    cnts("pre_reset", 1, 1);
    bp.res_valid_i = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    res_out("async_reset", 1'b0, 1'b0, 1'b0);
    cnts("async_reset", 0, 0);
    pred_at("reset_pred40", 32'h40, 1'b0);
    pred_at("reset_pred80", 32'h80, 1'b0);
    tick();
    reset = 1'b0;
    bp.res_valid_i = 1'b0;
    tick();
    res_out("after_reset", 1'b0, 1'b0, 1'b0);
    cnts("after_reset", 0, 0);
    pred_at("after_reset_pred44", 32'h44, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
